// File: rtl/spatz_pkg.sv
// +----------------------------------------------------------------------------+
// | spatz_pkg                                                                  |
// | Shared vector-register-file geometry and data types.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package spatz_pkg;

    localparam int unsigned NRVREG = 32;

    // Upper bits select the register, lower bits the element within it.
    typedef logic [9:0]  vreg_addr_t;
    typedef logic [31:0] vreg_data_t;

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// +----------------------------------------------------------------------------+
// | fifo_v3                                                                    |
// | Power-of-two depth synchronous FIFO with flush, common_cells port names.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned         c_addr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_addr_w:0]   c_depth   = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_cnt_one = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_count == c_depth);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; consumers only look at it while non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/spatz_vrf_read_streamer.sv
// +----------------------------------------------------------------------------+
// | spatz_vrf_read_streamer                                                    |
// | Streams consecutive VRF elements through one read port into a FIFO.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spatz_vrf_read_streamer
    import spatz_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  req_valid_i,
    output logic                                                  req_ready_o,
    input  logic [$clog2(NRVREG)-1:0]                             req_vreg_i,
    input  logic [$bits(vreg_addr_t)-$clog2(NRVREG)-1:0]          req_elem_i,
    input  logic [$bits(vreg_addr_t)-$clog2(NRVREG)+3:0]          req_len_i,
    output vreg_addr_t                                            raddr_o,
    output logic                                                  re_o,
    input  vreg_data_t                                            rdata_i,
    input  logic                                                  rvalid_i,
    output vreg_data_t                                            data_o,
    output logic                                                  data_last_o,
    output logic                                                  data_valid_o,
    input  logic                                                  data_ready_i,
    input  logic                                                  flush_i,
    output logic                                                  busy_o
);

    localparam int unsigned c_vreg_idx_w = $clog2(NRVREG);
    localparam int unsigned ElemIdxW     = $bits(vreg_addr_t) - c_vreg_idx_w;
    localparam int unsigned c_len_w      = ElemIdxW + 4;
    localparam int unsigned c_data_w     = $bits(vreg_data_t);
    localparam int unsigned c_payload_w  = c_data_w + 1;

    localparam logic [c_vreg_idx_w-1:0] c_vreg_one = c_vreg_idx_w'(1);
    localparam logic [ElemIdxW-1:0]     c_elem_one = ElemIdxW'(1);
    localparam logic [c_len_w-1:0]      c_len_one  = c_len_w'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]              r_state;
    logic [c_vreg_idx_w-1:0] r_vreg;
    logic [ElemIdxW-1:0]     r_elem;
    logic [c_len_w-1:0]      r_remaining;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_done;
    logic                    w_push;
    logic                    w_pop;
    logic [c_payload_w-1:0]  w_push_data;
    logic [c_payload_w-1:0]  w_fifo_out;

    // re_o depends only on registered state, never on data_ready_i.
    assign re_o        = (r_state == FETCH) && !w_full;
    assign w_done      = re_o && rvalid_i;
    assign w_push      = w_done && !flush_i;
    assign w_push_data = {(r_remaining == c_len_one), rdata_i};
    assign w_pop       = data_valid_o && data_ready_i;

    assign req_ready_o  = (r_state == IDLE);
    assign raddr_o      = {r_vreg, r_elem};
    assign data_valid_o = !w_empty;
    assign data_o       = data_valid_o ? w_fifo_out[c_data_w-1:0] : '0;
    assign data_last_o  = data_valid_o & w_fifo_out[c_payload_w-1];
    assign busy_o       = (r_state != IDLE) || !w_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_vreg      <= '0;
            r_elem      <= '0;
            r_remaining <= '0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Zero-length requests are accepted and dropped.
                    if (req_valid_i && (req_len_i != '0)) begin
                        r_vreg      <= req_vreg_i;
                        r_elem      <= req_elem_i;
                        r_remaining <= req_len_i;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_done) begin
                        r_elem      <= r_elem + c_elem_one;
                        if (r_elem == '1) r_vreg <= r_vreg + c_vreg_one;
                        r_remaining <= r_remaining - c_len_one;
                        if (r_remaining == c_len_one) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (c_payload_w),
        .DEPTH      (FIFO_DEPTH)
    ) u_buffer (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (flush_i),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (w_push_data),
        .push_i  (w_push),
        .data_o  (w_fifo_out),
        .pop_i   (w_pop)
    );

endmodule

`default_nettype wire

// File: tb/tb_spatz_vrf_read_streamer.sv
// +----------------------------------------------------------------------------+
// | tb_spatz_vrf_read_streamer                                                 |
// | Directed table-driven bench plus hand-written multi-cycle sequences.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spatz_vrf_read_streamer;
    import spatz_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  req_vreg_i;
    logic [4:0]  req_elem_i;
    logic [8:0]  req_len_i;
    vreg_addr_t  raddr_o;
    logic        re_o;
    vreg_data_t  rdata_i;
    logic        rvalid_i;
    vreg_data_t  data_o;
    logic        data_last_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        flush_i;
    logic        busy_o;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [32:0] q[$];

    always #5 clk = ~clk;

    // VRF model: each element's data encodes its own address.
    always_comb rdata_i = {16'hA5A5, 6'h00, raddr_o};

    spatz_vrf_read_streamer #(.FIFO_DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_vreg_i   (req_vreg_i),
        .req_elem_i   (req_elem_i),
        .req_len_i    (req_len_i),
        .raddr_o      (raddr_o),
        .re_o         (re_o),
        .rdata_i      (rdata_i),
        .rvalid_i     (rvalid_i),
        .data_o       (data_o),
        .data_last_o  (data_last_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic        req_valid;
        logic [4:0]  vreg;
        logic [4:0]  elem;
        logic [8:0]  len;
        logic        e_ready;
        logic        e_re;
        logic [9:0]  e_raddr;
        logic        e_dvalid;
        logic        e_last;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Record any handshake of the current cycle, then move to just after the next edge.
    task automatic next_cycle();
        if (data_valid_o && data_ready_i) q.push_back({data_last_o, data_o});
        @(posedge clk);
        #2;
    endtask

    task automatic start_req(input logic [4:0] v, input logic [4:0] e, input logic [8:0] l);
        req_valid_i = 1'b1; req_vreg_i = v; req_elem_i = e; req_len_i = l;
        next_cycle();
        req_valid_i = 1'b0;
        #1;
    endtask

    task automatic check_queue(input string name, input logic [32:0] exp[$]);
        check({name, " count"}, 32'(q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < q.size(); i++) begin
            check($sformatf("%s data%0d", name, i), q[i][31:0], exp[i][31:0]);
            check($sformatf("%s last%0d", name, i), {31'h0, q[i][32]}, {31'h0, exp[i][32]});
        end
    endtask

    initial begin
        logic [32:0] exp_q[$];

        vecs[0] = '{1'b1, 5'd3, 5'd0, 9'd4, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b0, 1'b1, 10'h060, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[2] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b0, 1'b1, 10'h061, 1'b1, 1'b0, 32'hA5A5_0060, 1'b1};
        vecs[3] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b0, 1'b1, 10'h062, 1'b1, 1'b0, 32'hA5A5_0061, 1'b1};
        vecs[4] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b0, 1'b1, 10'h063, 1'b1, 1'b0, 32'hA5A5_0062, 1'b1};
        vecs[5] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b1, 1'b0, 10'h064, 1'b1, 1'b1, 32'hA5A5_0063, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b1, 1'b0, 10'h064, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 5'd7, 5'd9, 9'd0, 1'b1, 1'b0, 10'h064, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 5'd0, 9'd0, 1'b1, 1'b0, 10'h064, 1'b0, 1'b0, 32'h0, 1'b0};

        rst_i = 1'b1; req_valid_i = 1'b0; req_vreg_i = '0; req_elem_i = '0; req_len_i = '0;
        rvalid_i = 1'b1; data_ready_i = 1'b1; flush_i = 1'b0;
        #3;
        check("reset req_ready", {31'h0, req_ready_o}, 32'h1);
        check("reset re", {31'h0, re_o}, 32'h0);
        check("reset busy", {31'h0, busy_o}, 32'h0);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;

        // Basic stream then a zero-length request, one row per cycle.
        for (int i = 0; i < 9; i++) begin
            req_valid_i = vecs[i].req_valid; req_vreg_i = vecs[i].vreg;
            req_elem_i  = vecs[i].elem;      req_len_i  = vecs[i].len;
            #1;
            check($sformatf("row%0d req_ready", i), {31'h0, req_ready_o}, {31'h0, vecs[i].e_ready});
            check($sformatf("row%0d re", i), {31'h0, re_o}, {31'h0, vecs[i].e_re});
            check($sformatf("row%0d raddr", i), {22'h0, raddr_o}, {22'h0, vecs[i].e_raddr});
            check($sformatf("row%0d dvalid", i), {31'h0, data_valid_o}, {31'h0, vecs[i].e_dvalid});
            check($sformatf("row%0d last", i), {31'h0, data_last_o}, {31'h0, vecs[i].e_last});
            check($sformatf("row%0d data", i), data_o, vecs[i].e_data);
            check($sformatf("row%0d busy", i), {31'h0, busy_o}, {31'h0, vecs[i].e_busy});
            next_cycle();
        end
        req_valid_i = 1'b0;

        // Element index wrap carries into the register index, which wraps too.
        q.delete();
        start_req(5'd31, 5'd31, 9'd2);
        check("wrap addr0", {22'h0, raddr_o}, 32'h3FF);
        next_cycle(); #1;
        check("wrap addr1", {22'h0, raddr_o}, 32'h000);
        for (int i = 0; i < 4; i++) next_cycle();
        exp_q = '{{1'b0, 32'hA5A5_03FF}, {1'b1, 32'hA5A5_0000}};
        check_queue("wrap", exp_q);

        // Backpressure: buffer fills after FIFO_DEPTH reads, then drains in order.
        q.delete();
        data_ready_i = 1'b0;
        start_req(5'd1, 5'd0, 9'd6);
        check("bp re c1", {31'h0, re_o}, 32'h1);
        next_cycle(); #1;
        check("bp re c2", {31'h0, re_o}, 32'h1);
        next_cycle(); #1;
        check("bp re full", {31'h0, re_o}, 32'h0);
        check("bp addr held", {22'h0, raddr_o}, 32'h022);
        next_cycle(); #1;
        check("bp re still 0", {31'h0, re_o}, 32'h0);
        check("bp head data", data_o, 32'hA5A5_0020);
        data_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) next_cycle();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5), 16'hA5A5, 16'h0020 + 16'(i)});
        check_queue("bp", exp_q);
        check("bp busy end", {31'h0, busy_o}, 32'h0);

        // Lost bank arbitration holds the address for cycles 2-4.
        q.delete();
        start_req(5'd2, 5'd5, 9'd3);
        next_cycle();
        rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("conflict hold%0d", i), {22'h0, raddr_o}, 32'h046);
            next_cycle();
        end
        rvalid_i = 1'b1;
        for (int i = 0; i < 6; i++) next_cycle();
        exp_q = '{{1'b0, 32'hA5A5_0045}, {1'b0, 32'hA5A5_0046}, {1'b1, 32'hA5A5_0047}};
        check_queue("conflict", exp_q);

        // Flush in cycle 3 of an 8-element stream.
        start_req(5'd4, 5'd0, 9'd8);
        next_cycle();
        next_cycle();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        #1;
        check("flush dvalid", {31'h0, data_valid_o}, 32'h0);
        check("flush req_ready", {31'h0, req_ready_o}, 32'h1);
        check("flush busy", {31'h0, busy_o}, 32'h0);
        q.delete();
        for (int i = 0; i < 3; i++) next_cycle();
        check("flush no output", 32'(q.size()), 32'h0);

        // Asynchronous reset between edges while a stream is in flight.
        start_req(5'd5, 5'd0, 9'd8);
        next_cycle();
        next_cycle();
        rst_i = 1'b1;
        #1;
        check("arst re", {31'h0, re_o}, 32'h0);
        check("arst raddr", {22'h0, raddr_o}, 32'h0);
        check("arst dvalid", {31'h0, data_valid_o}, 32'h0);
        check("arst data", data_o, 32'h0);
        check("arst last", {31'h0, data_last_o}, 32'h0);
        check("arst busy", {31'h0, busy_o}, 32'h0);
        check("arst req_ready", {31'h0, req_ready_o}, 32'h1);
        next_cycle();
        rst_i = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("post-rst re%0d", i), {31'h0, re_o}, 32'h0);
            next_cycle();
        end
        check("post-rst no output", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
